sync_pkt_fifo: RTL and testbench

SYNC_PKT_FIFO -- requirements
Module: sync_pkt_fifo

---
 rtl/sync_fifo_pkg.sv | 9 +
 rtl/sync_fifo_mem.sv | 25 ++
 rtl/sync_pkt_fifo.sv | 80 ++++++++
 tb/tb_sync_pkt_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: write-FSM state type, default sizes and pointer-width helper for sync_pkt_fifo
package sync_fifo_pkg;
  typedef enum logic {ACCEPT = 1'b0, DISCARD = 1'b1} wr_state_e;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port storage; we_i/waddr_i/wdata_i sync write, q_o async read of raddr_i, rq_o registered on re_i
module sync_fifo_mem #(
  parameter int P_WIDTH = 9,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [P_ADDR_WIDTH-1:0] waddr_i,
  input  logic [P_WIDTH-1:0]      wdata_i,
  input  logic                    re_i,
  input  logic [P_ADDR_WIDTH-1:0] raddr_i,
  output logic [P_WIDTH-1:0]      q_o,
  output logic [P_WIDTH-1:0]      rq_o
);
  logic [P_WIDTH-1:0] r_mem [2**P_ADDR_WIDTH];
  logic [P_WIDTH-1:0] r_rq;
  assign q_o = r_mem[raddr_i];
  assign rq_o = r_rq;
  always_ff @(posedge clk_i)
    if (we_i) r_mem[waddr_i] <= wdata_i;
  always_ff @(posedge clk_i)
    if (rst_i) r_rq <= '0;
    else if (re_i) r_rq <= r_mem[raddr_i];
endmodule

// File: rtl/sync_pkt_fifo.sv
// sync_pkt_fifo: packet FIFO with staged writes committed on wr_last_i, dropped on wr_drop_i or overflow; status empty/full/afull/fill/pkt_cnt/overflow
module sync_pkt_fifo
  import sync_fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int P_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int P_FWFT = 1,
  parameter int P_AFULL = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_i,
  input  logic [P_DATA_WIDTH-1:0] data_i,
  input  logic                    wr_last_i,
  input  logic                    wr_drop_i,
  input  logic                    rd_i,
  output logic [P_DATA_WIDTH-1:0] data_o,
  output logic                    rd_last_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    afull_o,
  output logic [P_ADDR_WIDTH:0]   fill_level_o,
  output logic [P_ADDR_WIDTH:0]   pkt_cnt_o,
  output logic                    overflow_o
);
  localparam int PW = ptr_w(P_ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH = PW'(2 ** P_ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL = PW'(P_AFULL);
  wr_state_e r_state, w_state_nx;
  logic [PW-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_pkt_cnt, w_wr_ptr_nx, w_used;
  logic r_ovf, w_acc, w_we, w_commit, w_ovf, w_re, w_pop_last;
  logic [P_DATA_WIDTH:0] w_q, w_rq;
  assign w_used = r_wr_ptr - r_rd_ptr;
  assign full_o = w_used == DEPTH;
  assign afull_o = w_used >= AFULL;
  assign empty_o = r_rd_ptr == r_cm_ptr;
  assign fill_level_o = r_cm_ptr - r_rd_ptr;
  assign pkt_cnt_o = r_pkt_cnt;
  assign overflow_o = r_ovf;
  assign w_re = rd_i & ~empty_o;
  assign w_pop_last = w_re & w_q[P_DATA_WIDTH];
  assign {rd_last_o, data_o} = P_FWFT != 0 ? (empty_o ? '0 : w_q) : w_rq;
  always_comb begin
    w_acc = r_state == ACCEPT;
    w_we = w_acc & wr_i & ~full_o & ~wr_drop_i;
    w_commit = w_we & wr_last_i;
    w_ovf = w_acc & wr_i & full_o & ~wr_drop_i;
    w_wr_ptr_nx = (wr_drop_i | w_ovf) ? r_cm_ptr : w_we ? r_wr_ptr + PW'(1) : r_wr_ptr;
    w_state_nx = w_acc ? ((w_ovf & ~wr_last_i) ? DISCARD : ACCEPT)
                       : (((wr_i & wr_last_i) | wr_drop_i) ? ACCEPT : DISCARD);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ACCEPT;
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_rd_ptr <= '0;
      r_pkt_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wr_ptr <= w_wr_ptr_nx;
      if (w_commit) r_cm_ptr <= r_wr_ptr + PW'(1);
      if (w_re) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_pkt_cnt <= r_pkt_cnt + PW'(w_commit) - PW'(w_pop_last);
      r_ovf <= w_ovf;
    end
  end
  sync_fifo_mem #(.P_WIDTH(P_DATA_WIDTH + 1), .P_ADDR_WIDTH(P_ADDR_WIDTH)) u_mem (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .we_i(w_we),
    .waddr_i(r_wr_ptr[P_ADDR_WIDTH-1:0]),
    .wdata_i({wr_last_i, data_i}),
    .re_i(w_re),
    .raddr_i(r_rd_ptr[P_ADDR_WIDTH-1:0]),
    .q_o(w_q),
    .rq_o(w_rq)
  );
endmodule

// File: tb/tb_sync_pkt_fifo.sv
// tb_sync_pkt_fifo: table vectors, directed corner sequences and random packets checked against a queue model for FWFT and registered-read instances
module tb_sync_pkt_fifo;
  logic clk = 1'b0;
  logic rst_i, wr_i, wr_last_i, wr_drop_i, rd_i;
  logic [7:0] data_i, d0, d1;
  logic l0, l1, e0, e1, f0, f1, af0, af1, ov0, ov1;
  logic [4:0] fl0, fl1, pc0, pc1;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] q[$], staged[$];
  logic [8:0] exp_rq;
  bit m_disc, m_ovf;
  typedef struct {
    bit wr; bit [7:0] d; bit last; bit drop; bit rd;
    bit e; int fill; int pkt; bit [8:0] hd;
  } vec_t;
  vec_t tbl[19];
  always #5 clk = ~clk;
  sync_pkt_fifo #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_FWFT(1), .P_AFULL(12)) u0 (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .data_i(data_i), .wr_last_i(wr_last_i),
    .wr_drop_i(wr_drop_i), .rd_i(rd_i), .data_o(d0), .rd_last_o(l0), .empty_o(e0),
    .full_o(f0), .afull_o(af0), .fill_level_o(fl0), .pkt_cnt_o(pc0), .overflow_o(ov0));
  sync_pkt_fifo #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_FWFT(0), .P_AFULL(12)) u1 (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .data_i(data_i), .wr_last_i(wr_last_i),
    .wr_drop_i(wr_drop_i), .rd_i(rd_i), .data_o(d1), .rd_last_o(l1), .empty_o(e1),
    .full_o(f1), .afull_o(af1), .fill_level_o(fl1), .pkt_cnt_o(pc1), .overflow_o(ov1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int mcnt();
    int c = 0;
    foreach (q[i]) c += int'(q[i][8]);
    return c;
  endfunction
  task automatic model_reset();
    q.delete();
    staged.delete();
    exp_rq = '0;
    m_disc = 0;
    m_ovf = 0;
  endtask
  task automatic chk_reset();
    chk("rst_empty0", e0, 1); chk("rst_empty1", e1, 1);
    chk("rst_full0", f0, 0); chk("rst_full1", f1, 0);
    chk("rst_afull0", af0, 0); chk("rst_afull1", af1, 0);
    chk("rst_ovf0", ov0, 0); chk("rst_ovf1", ov1, 0);
    chk("rst_data0", {l0, d0}, 0); chk("rst_data1", {l1, d1}, 0);
    chk("rst_fill0", fl0, 0); chk("rst_fill1", fl1, 0);
    chk("rst_pkt0", pc0, 0); chk("rst_pkt1", pc1, 0);
  endtask
  task automatic do_reset();
    {wr_i, wr_last_i, wr_drop_i, rd_i} = '0;
    data_i = '0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    model_reset();
  endtask
  task automatic cycle(input bit wr, input bit [7:0] d, input bit last, input bit drop, input bit rd);
    int used;
    wr_i = wr; data_i = d; wr_last_i = last; wr_drop_i = drop; rd_i = rd;
    used = staged.size() + q.size();
    chk("empty0", e0, q.size() == 0); chk("empty1", e1, q.size() == 0);
    chk("full0", f0, used == 16); chk("full1", f1, used == 16);
    chk("afull0", af0, used >= 12); chk("afull1", af1, used >= 12);
    chk("fill0", fl0, q.size()); chk("fill1", fl1, q.size());
    chk("pkt0", pc0, mcnt()); chk("pkt1", pc1, mcnt());
    chk("ovf0", ov0, m_ovf); chk("ovf1", ov1, m_ovf);
    chk("fwft_data", {l0, d0}, q.size() != 0 ? q[0] : 9'h0);
    chk("reg_data", {l1, d1}, exp_rq);
    m_ovf = 0;
    if (rd && q.size() != 0) exp_rq = q.pop_front();
    if (drop) begin
      staged.delete();
      m_disc = 0;
    end else if (!m_disc && wr) begin
      if (used == 16) begin
        m_ovf = 1;
        staged.delete();
        m_disc = !last;
      end else begin
        staged.push_back({last, d});
        if (last) begin
          foreach (staged[i]) q.push_back(staged[i]);
          staged.delete();
        end
      end
    end else if (m_disc && wr && last) m_disc = 0;
    @(posedge clk); #1;
  endtask
  initial begin
    int len, k, rdp;
    bit w, dr, r;
    tbl[0]  = '{1, 8'h11, 0, 0, 0, 1, 0, 0, 9'h000};
    tbl[1]  = '{1, 8'h12, 0, 0, 0, 1, 0, 0, 9'h000};
    tbl[2]  = '{1, 8'h13, 0, 0, 0, 1, 0, 0, 9'h000};
    tbl[3]  = '{1, 8'h14, 0, 0, 0, 1, 0, 0, 9'h000};
    tbl[4]  = '{1, 8'h15, 1, 0, 0, 0, 5, 1, 9'h011};
    tbl[5]  = '{0, 8'h00, 0, 0, 1, 0, 4, 1, 9'h012};
    tbl[6]  = '{0, 8'h00, 0, 0, 1, 0, 3, 1, 9'h013};
    tbl[7]  = '{0, 8'h00, 0, 0, 1, 0, 2, 1, 9'h014};
    tbl[8]  = '{0, 8'h00, 0, 0, 1, 0, 1, 1, 9'h115};
    tbl[9]  = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 9'h000};
    tbl[10] = '{1, 8'h21, 0, 0, 0, 1, 0, 0, 9'h000};
    tbl[11] = '{1, 8'h22, 0, 0, 0, 1, 0, 0, 9'h000};
    tbl[12] = '{1, 8'h23, 0, 0, 0, 1, 0, 0, 9'h000};
    tbl[13] = '{1, 8'h24, 0, 1, 0, 1, 0, 0, 9'h000};
    tbl[14] = '{1, 8'h31, 0, 0, 0, 1, 0, 0, 9'h000};
    tbl[15] = '{1, 8'h32, 1, 0, 0, 0, 2, 1, 9'h031};
    tbl[16] = '{0, 8'h00, 0, 0, 1, 0, 1, 1, 9'h132};
    tbl[17] = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 9'h000};
    tbl[18] = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 9'h000};
    do_reset();
    chk_reset();
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].wr, tbl[i].d, tbl[i].last, tbl[i].drop, tbl[i].rd);
      chk($sformatf("vec%0d_empty", i), e0, tbl[i].e);
      chk($sformatf("vec%0d_fill", i), fl0, tbl[i].fill);
      chk($sformatf("vec%0d_pkt", i), pc0, tbl[i].pkt);
      chk($sformatf("vec%0d_head", i), {l0, d0}, tbl[i].hd);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1, 8'(8'h40 + i), 0, 0, 0);
      if (i == 11) chk("staged_afull", af0, 1);
    end
    chk("staged_full", f0, 1);
    chk("staged_fill", fl0, 0);
    cycle(1, 8'h50, 0, 0, 0);
    chk("ovf_pulse", ov0, 1);
    chk("ovf_full_clr", f0, 0);
    cycle(1, 8'h51, 0, 0, 0);
    chk("ovf_no_repulse", ov0, 0);
    cycle(1, 8'h52, 1, 0, 0);
    chk("discard_empty", e0, 1);
    chk("discard_fill", fl0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h60 + i), i == 2, 0, 0);
    chk("after_ovf_fill", fl0, 3);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    chk("after_ovf_empty", e0, 1);
    for (int i = 0; i < 12; i++) begin
      if (i == 11) chk("afull_11", af0, 0);
      cycle(1, 8'(8'h70 + i), i == 11, 0, 0);
    end
    chk("afull_12", af0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("afull_pop", af0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h80 + i), i == 4, 0, 0);
    chk("full_commit", f0, 1);
    chk("full_fill", fl0, 16);
    chk("full_pkt", pc0, 2);
    cycle(1, 8'h90, 0, 0, 1);
    chk("pop_wr_ovf", ov0, 1);
    chk("pop_wr_fill", fl0, 15);
    chk("pop_wr_full", f0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 1);
    chk("drain_empty", e0, 1);
    chk("drain_pkt", pc0, 0);
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 6);
      k = 0;
      rdp = (p % 20 < 4) ? 10 : 50;
      while (k < len) begin
        w = $urandom_range(0, 3) != 0;
        dr = $urandom_range(0, 99) == 0;
        r = $urandom_range(0, 99) < rdp;
        cycle(w, 8'($urandom), w && k == len - 1, dr, r);
        if (w) k++;
      end
    end
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 0, 1);
    chk("rand_empty", e0, 1);
    for (int i = 0; i < 2; i++) cycle(1, 8'(8'hA0 + i), i == 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'hB0 + i), i == 2, 0, 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) cycle(1, 8'(8'hC0 + i), 0, 0, 0);
    chk("pre_rst_pkt", pc0, 2);
    chk("pre_rst_reg_data", {l1, d1}, 9'h0A0);
    do_reset();
    chk_reset();
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'hD0 + i), i == 3, 0, 0);
    chk("post_rst_fill", fl0, 4);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
    chk("post_rst_empty", e0, 1);
    chk("post_rst_reg_data", {l1, d1}, 9'h1D3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
